// File: rtl/atomic_controller_pkg.sv
// Shared definitions for the RV32A atomic sequencer.
//   - funct5 codes for every AMO, plus LR and SC
//   - FSM state encoding used by atomic_controller
//   - small decode helper for SC requests
package atomic_controller_pkg;

    localparam logic [4:0] ATOMIC_ADD_OP  = 5'b00000;
    localparam logic [4:0] ATOMIC_SWAP_OP = 5'b00001;
    localparam logic [4:0] ATOMIC_LR_OP   = 5'b00010;
    localparam logic [4:0] ATOMIC_SC_OP   = 5'b00011;
    localparam logic [4:0] ATOMIC_XOR_OP  = 5'b00100;
    localparam logic [4:0] ATOMIC_OR_OP   = 5'b01000;
    localparam logic [4:0] ATOMIC_AND_OP  = 5'b01100;
    localparam logic [4:0] ATOMIC_MIN_OP  = 5'b10000;
    localparam logic [4:0] ATOMIC_MAX_OP  = 5'b10100;
    localparam logic [4:0] ATOMIC_MINU_OP = 5'b11000;
    localparam logic [4:0] ATOMIC_MAXU_OP = 5'b11100;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_READ  = 2'd1,
        STATE_WRITE = 2'd2,
        STATE_DONE  = 2'd3
    } state_t;

    function automatic logic is_sc(input logic [4:0] funct5);
        return funct5 == ATOMIC_SC_OP;
    endfunction

endpackage

// File: rtl/atomic_controller_alu.sv
// Combinational AMO ALU: result = op(a, b).
//   a      : old memory word
//   b      : rs2 operand
//   op     : funct5 code
//   result : value to write back; 0 for any code that is not an AMO
module atomic
    import atomic_controller_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ATOMIC_ADD_OP:  result = a + b;
            ATOMIC_SWAP_OP: result = b;
            ATOMIC_XOR_OP:  result = a ^ b;
            ATOMIC_OR_OP:   result = a | b;
            ATOMIC_AND_OP:  result = a & b;
            ATOMIC_MIN_OP:  result = ($signed(a) < $signed(b)) ? a : b;
            ATOMIC_MAX_OP:  result = ($signed(a) > $signed(b)) ? a : b;
            ATOMIC_MINU_OP: result = (a < b) ? a : b;
            ATOMIC_MAXU_OP: result = (a > b) ? a : b;
            default:        result = '0;
        endcase
    end

endmodule

// File: rtl/atomic_controller.sv
// RV32A sequencer: runs one AMO/LR/SC read-modify-write against the data
// memory port and owns the single LR/SC reservation.
//   clock, reset        : clock, synchronous active-high reset
//   start/op/address/operand : request from execute (accepted only in IDLE)
//   busy                : state != IDLE (pipeline stall)
//   done/rd_data        : one-cycle completion pulse with the rd value
//   mem_*               : registered memory request, completed by mem_ready
//   snoop_write/address : stores from other masters, kill the reservation
module atomic_controller
    import atomic_controller_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [4:0]               op,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [31:0]              operand,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              rd_data,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [31:0]              mem_write_data,
    input  logic [31:0]              mem_read_data,
    input  logic                     mem_ready,
    input  logic                     snoop_write,
    input  logic [ADDRESS_WIDTH-1:0] snoop_address
);

    localparam int TAG_WIDTH = ADDRESS_WIDTH - 2;

    state_t                 state_reg, state_next;
    logic [4:0]             op_reg, op_next;
    logic [TAG_WIDTH-1:0]   tag_reg, tag_next;
    logic [31:0]            operand_reg, operand_next;
    logic [31:0]            old_reg, old_next;
    logic                   resv_valid_reg, resv_valid_next;
    logic [TAG_WIDTH-1:0]   resv_tag_reg, resv_tag_next;
    logic                   done_reg, done_next;
    logic [31:0]            rd_data_reg, rd_data_next;
    logic                   mem_read_reg, mem_read_next;
    logic                   mem_write_reg, mem_write_next;
    logic [ADDRESS_WIDTH-1:0] mem_address_reg, mem_address_next;
    logic [31:0]            mem_write_data_reg, mem_write_data_next;

    logic [31:0]            alu_a;
    logic [31:0]            alu_result;
    logic                   unused_low_bits;

    // Word granularity only: byte offsets never reach the state.
    assign unused_low_bits = ^{address[1:0], snoop_address[1:0]};

    // The write data must be registered on the same edge that captures the
    // read word, so the ALU sees the incoming word while it is being latched.
    assign alu_a = (state_reg == STATE_READ && mem_ready) ? mem_read_data : old_reg;

    atomic u_atomic (
        .a      (alu_a),
        .b      (operand_reg),
        .op     (op_reg),
        .result (alu_result)
    );

    always_comb begin
        state_next          = state_reg;
        op_next             = op_reg;
        tag_next            = tag_reg;
        operand_next        = operand_reg;
        old_next            = old_reg;
        resv_valid_next     = resv_valid_reg;
        resv_tag_next       = resv_tag_reg;
        done_next           = 1'b0;
        rd_data_next        = rd_data_reg;
        mem_read_next       = 1'b0;
        mem_write_next      = 1'b0;
        mem_address_next    = mem_address_reg;
        mem_write_data_next = mem_write_data_reg;

        // A foreign store to the reserved word kills the reservation in any
        // state; the LR completion below is allowed to override this.
        if (snoop_write && snoop_address[ADDRESS_WIDTH-1:2] == resv_tag_reg) begin
            resv_valid_next = 1'b0;
        end

        case (state_reg)
            STATE_IDLE: begin
                if (start) begin
                    op_next      = op;
                    tag_next     = address[ADDRESS_WIDTH-1:2];
                    operand_next = operand;
                    if (is_sc(op)) begin
                        // SC success is decided here, once; later snoops
                        // do not abort a write already granted.
                        if (resv_valid_reg && resv_tag_reg == address[ADDRESS_WIDTH-1:2]) begin
                            state_next          = STATE_WRITE;
                            mem_write_next      = 1'b1;
                            mem_address_next    = {address[ADDRESS_WIDTH-1:2], 2'b00};
                            mem_write_data_next = operand;
                        end else begin
                            state_next   = STATE_DONE;
                            done_next    = 1'b1;
                            rd_data_next = 32'd1;
                        end
                    end else begin
                        state_next       = STATE_READ;
                        mem_read_next    = 1'b1;
                        mem_address_next = {address[ADDRESS_WIDTH-1:2], 2'b00};
                    end
                end
            end

            STATE_READ: begin
                if (mem_ready) begin
                    old_next = mem_read_data;
                    if (op_reg == ATOMIC_LR_OP) begin
                        // LR saw pre-store data, so a same-cycle snoop
                        // must not prevent the reservation being set.
                        resv_valid_next = 1'b1;
                        resv_tag_next   = tag_reg;
                        state_next      = STATE_DONE;
                        done_next       = 1'b1;
                        rd_data_next    = mem_read_data;
                    end else begin
                        state_next          = STATE_WRITE;
                        mem_write_next      = 1'b1;
                        mem_write_data_next = alu_result;
                    end
                end else begin
                    mem_read_next = 1'b1;
                end
            end

            STATE_WRITE: begin
                // Our own AMO store to the reserved word breaks the LR/SC pair.
                if (!is_sc(op_reg) && resv_tag_reg == tag_reg) begin
                    resv_valid_next = 1'b0;
                end
                if (mem_ready) begin
                    state_next   = STATE_DONE;
                    done_next    = 1'b1;
                    rd_data_next = is_sc(op_reg) ? 32'd0 : old_reg;
                end else begin
                    mem_write_next = 1'b1;
                end
            end

            STATE_DONE: begin
                if (is_sc(op_reg)) begin
                    resv_valid_next = 1'b0;
                end
                state_next = STATE_IDLE;
            end

            default: begin
                state_next = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= STATE_IDLE;
            op_reg             <= '0;
            tag_reg            <= '0;
            operand_reg        <= '0;
            old_reg            <= '0;
            resv_valid_reg     <= 1'b0;
            resv_tag_reg       <= '0;
            done_reg           <= 1'b0;
            rd_data_reg        <= '0;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= '0;
        end else begin
            state_reg          <= state_next;
            op_reg             <= op_next;
            tag_reg            <= tag_next;
            operand_reg        <= operand_next;
            old_reg            <= old_next;
            resv_valid_reg     <= resv_valid_next;
            resv_tag_reg       <= resv_tag_next;
            done_reg           <= done_next;
            rd_data_reg        <= rd_data_next;
            mem_read_reg       <= mem_read_next;
            mem_write_reg      <= mem_write_next;
            mem_address_reg    <= mem_address_next;
            mem_write_data_reg <= mem_write_data_next;
        end
    end

    assign busy           = (state_reg != STATE_IDLE);
    assign done           = done_reg;
    assign rd_data        = rd_data_reg;
    assign mem_read       = mem_read_reg;
    assign mem_write      = mem_write_reg;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;

endmodule

// File: doc/atomic_controller.md
# atomic_controller

Sequencer for RV32A instructions. It accepts one AMO/LR/SC request from the execute stage and runs the memory read-modify-write around the shared combinational `atomic` ALU. It holds the single LR/SC reservation. It sits between the execute stage and the data-memory port and stalls the pipeline through `busy` until it returns the `rd` value.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32: byte address width.

Ports:
- `clock`  input  1: single clock; all state changes on rising edge.
- `reset`  input  1: synchronous, active-high.
- `start`  input  1: one-cycle request strobe; ignored while `busy`.
- `op`  input  5: funct5; the ATOMIC_*_OP codes plus LR (00010) and SC (00011).
- `address`  input  32: word-aligned target address; bits [1:0] ignored.
- `operand`  input  32: rs2 value.
- `busy`  output  1: high from the cycle after `start` until `done`, inclusive.
- `done`  output  1: one-cycle pulse; `rd_data` valid that cycle.
- `rd_data`  output  32: old memory word (AMO/LR) or SC status (0 success, 1 fail).
- `mem_address`  output  32: memory word address.
- `mem_read`  output  1: read request, held until `mem_ready`.
- `mem_write`  output  1: write request, held until `mem_ready`.
- `mem_write_data`  output  32: write data.
- `mem_read_data`  input  32: valid in the cycle `mem_ready` is high during a read.
- `mem_ready`  input  1: completes the outstanding request; may be high in the first request cycle.
- `snoop_write`  input  1: another master's store this cycle.
- `snoop_address`  input  32: address of that store.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `start` latches `op`, `address`, `operand`.
  - AMO or LR goes to READ.
  - SC with a matching valid reservation goes to WRITE.
  - SC otherwise goes to DONE with `rd_data`=1 and no memory access.
- READ:
  - `mem_read`=1 until `mem_ready`.
  - On `mem_ready`, latch `mem_read_data` as `old`.
  - LR sets reservation {valid=1, address[31:2]} and goes to DONE.
  - AMO goes to WRITE.
- WRITE:
  - `mem_write`=1 until `mem_ready`.
  - `mem_write_data` is `atomic(old, operand, op)` for AMO, or `operand` for SC.
  - On `mem_ready`, go to DONE.
- DONE:
  - `done`=1.
  - `rd_data` is `old` for AMO/LR, 0 for a successful SC, 1 for a failed SC.
  - Then go to IDLE.
- Reservation match compares address bits [31:2] only.
- Reservation clears on:
  - any SC, success or fail, at its DONE;
  - `snoop_write` with a matching address, in any state;
  - reset.
- A write-phase AMO to the reserved word clears the reservation.
- A snoop clear that arrives while an SC is in WRITE does not abort that SC. The success decision is made in IDLE.
- Unknown `op`: treated as an AMO. The ALU returns 0, so 0 is written.
- `mem_address` = {latched address[31:2], 2'b00} whenever `mem_read` or `mem_write` is high.
- `mem_read` and `mem_write` are never high together.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `mem_read`, `mem_write` = 0;
  - `rd_data`, `mem_address`, `mem_write_data` = 0;
  - reservation invalid.
- Reset mid-operation:
  - outstanding request drops at the next edge;
  - no `done` pulse;
  - a memory response after reset is ignored.
- All outputs are registered except `busy`, which is decoded from the state (state ≠ IDLE).
- Minimum latency with `start` at cycle t and `mem_ready` always high:
  - AMO: READ t+1, WRITE t+2, `done` t+3;
  - LR: `done` t+2;
  - successful SC: `done` t+2;
  - failed SC: `done` t+1.
- Each `mem_ready` stall cycle adds one cycle of latency.
- `start` in the DONE cycle is ignored. The issuing stage must wait for `busy`=0.
- `snoop_write` in the same cycle as the LR's `mem_ready`: the reservation is still set, because the LR observed pre-store data. A later SC will fail only if a later snoop matches.

## Structure
- Shared defines package holds:
  - the ATOMIC_*_OP codes;
  - new `ATOMIC_LR_OP` and `ATOMIC_SC_OP` codes;
  - FSM state encodings.
- Sub-module: one instance of the existing combinational `atomic` ALU, with `a`=`old`, `b`=latched `operand`, `op`=latched op.
- Reservation register (valid bit + 30-bit tag) is local. No separate module.

## Test plan
- AMOADD, mem[0x100]=5, operand 3, ready always high → write 8 at t+2, `done` at t+3 with `rd_data`=5.
- AMOMAX, mem=0xFFFFFFFF, operand 1 → writes 1. AMOMAXU with the same operands → writes 0xFFFFFFFF. Both return 0xFFFFFFFF.
- LR 0x200 then SC 0x200 operand 0xABCD → SC writes 0xABCD, `rd_data`=0. A second SC → `rd_data`=1, no `mem_write`.
- LR 0x200, then `snoop_write` to 0x203, then SC → `rd_data`=1. Repeat with the snoop to 0x204 → `rd_data`=0.
- AMOSWAP with `mem_ready` low for 3 cycles in each phase → requests held stable, `done` at t+9, `start` during `busy` ignored.
- Reset asserted in WRITE → `mem_write` low the next cycle, no `done`, reservation invalid; a subsequent SC fails.
